pwm_ramp_ctrl: RTL and testbench

Sequencer that drives the configuration inputs of one 16-bit PWM channel: `period`, `compare` and `pwm_onoff`. It accepts ramp/stop commands over a valid/ready handshake. It enables the channel and steps `compare` toward a target by a fixed increment once per carrier period, using a one-cycle `period_tick` from the channel's mask event. It sits between the control register file and the PWM channel, giving soft-start and soft-stop without software timing.

---
 rtl/pwm_ramp_ctrl_if.sv | 30 +++
 rtl/pwm_ramp_ctrl.sv | 155 +++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_ctrl_if.sv
// Command channel between the control register file and the PWM ramp sequencer.
// Master issues ramp/stop commands; slave (the sequencer) returns cmd_ready.
interface pwm_ramp_ctrl_if #(
  parameter int W = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_stop;
  logic [W-1:0] cmd_target;
  logic [W-1:0] cmd_step;
  logic [W-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_stop,
    output cmd_target,
    output cmd_step,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_stop,
    input  cmd_target,
    input  cmd_step,
    input  cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for one PWM channel: steps compare toward a
// latched target by a fixed increment once per carrier period tick.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | channel off, compare held at 0, accepts commands
//   RAMP     | channel on, stepping compare toward target on each tick
//   HOLD     | channel on, compare at target, accepts commands
//   STOPPING | channel on, stepping compare toward 0, then switches off
module pwm_ramp_ctrl #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             reset,
  pwm_ramp_ctrl_if.slave   cmd,
  input  logic             abort,
  input  logic             period_tick,
  output logic [W-1:0]     period,
  output logic [W-1:0]     compare,
  output logic             pwm_onoff,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAMP     = 2'd1,
    HOLD     = 2'd2,
    STOPPING = 2'd3
  } state_t;

  state_t       state_q,   state_d;
  logic [W-1:0] period_q,  period_d;
  logic [W-1:0] compare_q, compare_d;
  logic [W-1:0] target_q,  target_d;
  logic [W-1:0] step_q,    step_d;
  logic         onoff_q,   onoff_d;
  logic         done_q,    done_d;
  logic         armed_q,   armed_d;

  logic         accept;
  logic         going_up;
  logic [W:0]   diff;
  logic         last_step;
  logic [W-1:0] clamped_target;

  // Ready is held low while reset is asserted and rises on the first edge after release.
  assign cmd.cmd_ready = armed_q & ((state_q == IDLE) | (state_q == HOLD));
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;

  assign clamped_target = (cmd.cmd_target < cmd.cmd_period) ? cmd.cmd_target : cmd.cmd_period;

  assign going_up  = (target_q >= compare_q);
  assign diff      = going_up ? ({1'b0, target_q} - {1'b0, compare_q})
                              : ({1'b0, compare_q} - {1'b0, target_q});
  assign last_step = (step_q == '0) || (diff <= {1'b0, step_q});

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    compare_d = compare_q;
    target_d  = target_q;
    step_d    = step_q;
    onoff_d   = onoff_q;
    done_d    = 1'b0;
    armed_d   = 1'b1;

    if (abort) begin
      state_d   = IDLE;
      compare_d = '0;
      onoff_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (cmd.cmd_stop) begin
              done_d = 1'b1;
            end else begin
              period_d  = cmd.cmd_period;
              target_d  = clamped_target;
              step_d    = cmd.cmd_step;
              compare_d = '0;
              onoff_d   = 1'b1;
              state_d   = RAMP;
            end
          end
        end
        HOLD: begin
          // A tick coinciding with an accept is dropped; stepping starts on the next tick.
          if (accept) begin
            step_d = cmd.cmd_step;
            if (cmd.cmd_stop) begin
              target_d = '0;
              state_d  = STOPPING;
            end else begin
              period_d = cmd.cmd_period;
              target_d = clamped_target;
              state_d  = RAMP;
            end
          end
        end
        RAMP, STOPPING: begin
          if (period_tick) begin
            if (last_step) begin
              compare_d = target_q;
              done_d    = 1'b1;
              if (state_q == STOPPING) begin
                onoff_d = 1'b0;
                state_d = IDLE;
              end else begin
                state_d = HOLD;
              end
            end else if (going_up) begin
              compare_d = compare_q + step_q;
            end else begin
              compare_d = compare_q - step_q;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      period_q  <= '0;
      compare_q <= '0;
      target_q  <= '0;
      step_q    <= '0;
      onoff_q   <= 1'b0;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      compare_q <= compare_d;
      target_q  <= target_d;
      step_q    <= step_d;
      onoff_q   <= onoff_d;
      done_q    <= done_d;
      armed_q   <= armed_d;
    end
  end

  assign period    = period_q;
  assign compare   = compare_q;
  assign pwm_onoff = onoff_q;
  assign done      = done_q;
  assign busy      = (state_q == RAMP) || (state_q == STOPPING);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed scenarios plus random commands, all checked
// every cycle against an arithmetic model of the ramp rules.
module tb_pwm_ramp_ctrl;

  localparam int W = 16;
  localparam int M_IDLE = 0, M_RAMP = 1, M_HOLD = 2, M_STOP = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          abort = 1'b0;
  logic          period_tick = 1'b0;
  logic [W-1:0]  period, compare;
  logic          pwm_onoff, busy, done;

  pwm_ramp_ctrl_if #(.W(W)) cmd_if ();

  pwm_ramp_ctrl #(.W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cmd_if),
    .abort       (abort),
    .period_tick (period_tick),
    .period      (period),
    .compare     (compare),
    .pwm_onoff   (pwm_onoff),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model of the channel configuration as seen after the most recent edge.
  int m_mode, m_period, m_compare, m_target, m_step, m_on, m_done, m_armed;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_period = 0; m_compare = 0; m_target = 0;
    m_step = 0; m_on = 0; m_done = 0; m_armed = 0;
  endtask

  function automatic int m_ready();
    return (m_armed != 0 && (m_mode == M_IDLE || m_mode == M_HOLD)) ? 1 : 0;
  endfunction

  // Applies the rules to the inputs present at the edge just taken.
  task automatic model_step();
    int acc, d, tgt;
    acc = (cmd_if.cmd_valid && m_ready() != 0) ? 1 : 0;
    tgt = (int'(cmd_if.cmd_target) < int'(cmd_if.cmd_period)) ? int'(cmd_if.cmd_target)
                                                              : int'(cmd_if.cmd_period);
    m_done = 0;
    if (abort) begin
      m_mode = M_IDLE; m_compare = 0; m_on = 0;
    end else if (m_mode == M_IDLE) begin
      if (acc != 0) begin
        if (cmd_if.cmd_stop) m_done = 1;
        else begin
          m_period = int'(cmd_if.cmd_period); m_target = tgt; m_step = int'(cmd_if.cmd_step);
          m_compare = 0; m_on = 1; m_mode = M_RAMP;
        end
      end
    end else if (m_mode == M_HOLD) begin
      if (acc != 0) begin
        m_step = int'(cmd_if.cmd_step);
        if (cmd_if.cmd_stop) begin
          m_target = 0; m_mode = M_STOP;
        end else begin
          m_period = int'(cmd_if.cmd_period); m_target = tgt; m_mode = M_RAMP;
        end
      end
    end else if (period_tick) begin
      d = m_target - m_compare;
      if (m_step == 0 || (d < 0 ? -d : d) <= m_step) begin
        m_compare = m_target; m_done = 1;
        if (m_mode == M_STOP) begin
          m_on = 0; m_mode = M_IDLE;
        end else m_mode = M_HOLD;
      end else m_compare = m_compare + ((d > 0) ? m_step : -m_step);
    end
    m_armed = 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("period",    int'(period),           m_period);
      chk("compare",   int'(compare),          m_compare);
      chk("pwm_onoff", int'(pwm_onoff),        m_on);
      chk("done",      int'(done),             m_done);
      chk("busy",      int'(busy),             (m_mode == M_RAMP || m_mode == M_STOP) ? 1 : 0);
      chk("cmd_ready", int'(cmd_if.cmd_ready), m_ready());
    end
  end

  task automatic clk_step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic set_cmd(input bit stop, input int tgt, input int stp, input int per);
    cmd_if.cmd_stop   = stop;
    cmd_if.cmd_target = W'(tgt);
    cmd_if.cmd_step   = W'(stp);
    cmd_if.cmd_period = W'(per);
  endtask

  task automatic send(input bit stop, input int tgt, input int stp, input int per);
    set_cmd(stop, tgt, stp, per);
    cmd_if.cmd_valid = 1'b1;
    clk_step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic tick();
    period_tick = 1'b1;
    clk_step();
    period_tick = 1'b0;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    @(negedge clk);
    #1;
    chk(name, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    set_cmd(1'b0, 0, 0, 0);
    model_reset();
    chk_en = 1'b1;
    do_reset();
    @(negedge clk);
    chk("reset_compare", int'(compare), 0);
    chk("reset_ready_before_edge", int'(cmd_if.cmd_ready), 0);
    clk_step();
    lit("ready_after_first_edge", int'(cmd_if.cmd_ready), 1);

    // Soft start 0 -> 1000 in steps of 250
    send(1'b0, 1000, 250, 2000);
    lit("start_period", int'(period), 2000);
    chk("start_onoff", int'(pwm_onoff), 1);
    tick(); lit("ramp_t1", int'(compare), 250);
    tick(); lit("ramp_t2", int'(compare), 500);
    tick(); lit("ramp_t3", int'(compare), 750);
    chk("ramp_t3_nodone", int'(done), 0);
    tick(); lit("ramp_t4", int'(compare), 1000);
    chk("ramp_t4_done", int'(done), 1);
    tick(); lit("ramp_t5_hold", int'(compare), 1000);
    chk("ramp_t5_nodone", int'(done), 0);

    // Ramp down with a non-multiple step, then soft stop
    send(1'b0, 300, 300, 2000);
    tick(); lit("down_t1", int'(compare), 700);
    tick(); lit("down_t2", int'(compare), 400);
    tick(); lit("down_t3", int'(compare), 300);
    chk("down_t3_done", int'(done), 1);
    send(1'b1, 0, 200, 0);
    tick(); lit("stop_t1", int'(compare), 100);
    chk("stop_t1_on", int'(pwm_onoff), 1);
    tick(); lit("stop_t2", int'(compare), 0);
    chk("stop_t2_off", int'(pwm_onoff), 0);
    chk("stop_t2_done", int'(done), 1);

    // Stop accepted while idle pulses done only
    send(1'b1, 0, 5, 0);
    lit("idle_stop_done", int'(done), 1);

    // Clamp to period with a single-tick jump
    send(1'b0, 5000, 0, 4000);
    tick(); lit("clamp_jump", int'(compare), 4000);
    chk("clamp_done", int'(done), 1);

    // Accept in HOLD coinciding with a tick: tick dropped
    set_cmd(1'b0, 1000, 1000, 4000);
    cmd_if.cmd_valid = 1'b1;
    period_tick = 1'b1;
    clk_step();
    cmd_if.cmd_valid = 1'b0;
    period_tick = 1'b0;
    lit("coincident_unchanged", int'(compare), 4000);
    chk("coincident_busy", int'(busy), 1);
    tick(); lit("coincident_first_step", int'(compare), 3000);
    tick(); tick();
    lit("coincident_end", int'(compare), 1000);

    // Abort beats a simultaneous accept
    set_cmd(1'b0, 2000, 10, 9999);
    cmd_if.cmd_valid = 1'b1;
    abort = 1'b1;
    clk_step();
    cmd_if.cmd_valid = 1'b0;
    abort = 1'b0;
    lit("abort_compare", int'(compare), 0);
    chk("abort_onoff", int'(pwm_onoff), 0);
    chk("abort_period", int'(period), 4000);
    chk("abort_nodone", int'(done), 0);

    // Command held valid during a ramp is accepted on the done cycle
    send(1'b0, 500, 250, 1000);
    set_cmd(1'b0, 100, 0, 1000);
    cmd_if.cmd_valid = 1'b1;
    clk_step(); clk_step();
    lit("stall_ready", int'(cmd_if.cmd_ready), 0);
    tick(); tick();
    lit("stall_done", int'(done), 1);
    chk("stall_done_ready", int'(cmd_if.cmd_ready), 1);
    clk_step();
    cmd_if.cmd_valid = 1'b0;
    lit("stall_accepted", int'(busy), 1);
    tick(); lit("stall_jump", int'(compare), 100);

    // Async reset between edges mid-ramp
    send(1'b0, 1000, 250, 2000);
    tick();
    @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
    #1;
    chk("async_compare", int'(compare), 0);
    chk("async_onoff", int'(pwm_onoff), 0);
    chk("async_period", int'(period), 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Random commands, ticks and aborts
    for (int i = 0; i < 4000; i++) begin
      cmd_if.cmd_valid  = ($urandom_range(0, 2) == 0);
      cmd_if.cmd_stop   = ($urandom_range(0, 3) == 0);
      cmd_if.cmd_target = W'($urandom_range(0, 2500));
      cmd_if.cmd_period = W'($urandom_range(0, 3000));
      cmd_if.cmd_step   = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 600));
      period_tick       = ($urandom_range(0, 2) == 0);
      abort             = ($urandom_range(0, 80) == 0);
      if (i % 16 == 0) cmd_if.cmd_target = 16'hFFFF;
      clk_step();
    end
    cmd_if.cmd_valid = 1'b0;
    period_tick = 1'b0;
    abort = 1'b0;
    clk_step();
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
